// File: rtl/ifu_prefetch.sv
// Instruction fetch front end: PC, ROM word reads, 2-entry prefetch FIFO whose head feeds IF/ID.
// ROM request to instr_o takes 2 cycles; hold stops fetching once FIFO + in-flight reach 2; jump flushes and redirects.
module ifu_prefetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 'h00000013
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  rom_req_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  hold_flag_i,
  input  logic                  jump_flag_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  instr_valid_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] addr;
  } entry_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  entry_t                fifo_q [2];
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;
  logic                  inflight_q;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  pop, push;
  logic [2:0]            occupancy;

  assign instr_valid_o = (count_q != 2'd0);
  assign instr_o       = instr_valid_o ? fifo_q[rd_ptr_q].instr : NOP_INSTR;
  assign instr_addr_o  = instr_valid_o ? fifo_q[rd_ptr_q].addr  : '0;

  always_comb begin
    pop       = instr_valid_o & ~hold_flag_i & ~jump_flag_i;
    // A response landing in a jump cycle belongs to the pre-jump stream and is discarded.
    push      = inflight_q & ~jump_flag_i;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    rom_req_o  = 1'b0;
    rom_addr_o = pc_q;
    if (rstn) begin
      if (jump_flag_i) begin
        rom_req_o  = 1'b1;
        rom_addr_o = jump_addr_i;
      end else begin
        rom_req_o = (occupancy < (3'd2 + {2'b00, pop}));
      end
    end

    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (jump_flag_i) begin
      pc_d     = jump_addr_i + ADDR_ONE;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (rom_req_o) pc_d = pc_q + ADDR_ONE;
      if (pop)       rd_ptr_d = ~rd_ptr_q;
      if (push)      wr_ptr_d = ~wr_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q            <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      fifo_q[0]       <= '0;
      fifo_q[1]       <= '0;
    end else begin
      pc_q            <= pc_d;
      inflight_q      <= rom_req_o;
      inflight_addr_q <= rom_addr_o;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      if (push) fifo_q[wr_ptr_q] <= {rom_data_i, inflight_addr_q};
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(push && !pop && count_q == 2'd2))
        else $error("ifu_prefetch: prefetch FIFO overflow");
    end
  end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch against a queue-based fetch model, plus directed redirect/hold/reset cases.
module tb_ifu_prefetch;
  localparam int          DW  = 32;
  localparam int          AW  = 12;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rom_req_o;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] rom_data_i = 32'hDEADBEEF;
  logic          hold_flag_i = 1'b0;
  logic          jump_flag_i = 1'b0;
  logic [AW-1:0] jump_addr_i = '0;
  logic [DW-1:0] instr_o;
  logic [AW-1:0] instr_addr_o;
  logic          instr_valid_o;

  always #5 clk = ~clk;

  ifu_prefetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rstn(rstn),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .hold_flag_i(hold_flag_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .instr_o(instr_o), .instr_addr_o(instr_addr_o), .instr_valid_o(instr_valid_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of buffered addresses, one outstanding ROM request, next PC.
  logic [AW-1:0] mq[$];
  bit            m_pend = 1'b0;
  logic [AW-1:0] m_pend_addr = '0;
  logic [AW-1:0] m_pc = '0;

  logic          obs_req, obs_vld;
  logic [AW-1:0] obs_raddr, obs_iaddr;
  logic [DW-1:0] obs_instr;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return 32'hA500_0000 | (32'(a) << 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model, answer ROM request.
  task automatic step(input bit r, input bit h, input bit j, input logic [AW-1:0] ja);
    bit            pop, ereq, evld;
    int            occ;
    logic [AW-1:0] eraddr;
    rstn        = ~r;
    hold_flag_i = h;
    jump_flag_i = j;
    jump_addr_i = ja;
    @(negedge clk);
    obs_req   = rom_req_o;
    obs_raddr = rom_addr_o;
    obs_vld   = instr_valid_o;
    obs_iaddr = instr_addr_o;
    obs_instr = instr_o;
    evld = !r && (mq.size() > 0);
    chk("valid", 32'(obs_vld), 32'(evld));
    chk("iaddr", 32'(obs_iaddr), evld ? 32'(mq[0]) : 32'h0);
    chk("instr", obs_instr, evld ? rom_f(mq[0]) : NOP);
    if (r) begin
      chk("req_rst", 32'(obs_req), 32'h0);
      mq.delete();
      m_pend = 1'b0;
      m_pc   = '0;
    end else begin
      pop    = evld && !h && !j;
      occ    = mq.size() + int'(m_pend) - int'(pop);
      ereq   = j || (occ < 2);
      eraddr = j ? ja : m_pc;
      chk("req", 32'(obs_req), 32'(ereq));
      if (ereq) chk("raddr", 32'(obs_raddr), 32'(eraddr));
      if (j) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (m_pend) mq.push_back(m_pend_addr);
      end
      m_pend      = ereq;
      m_pend_addr = eraddr;
      if (j) m_pc = ja + AW'(1);
      else if (ereq) m_pc = m_pc + AW'(1);
    end
    @(posedge clk);
    #1;
    rom_data_i = obs_req ? rom_f(obs_raddr) : 32'hDEADBEEF;
  endtask

  initial begin
    bit            r, h, j;
    logic [AW-1:0] ja;

    step(1, 0, 0, '0);
    step(1, 0, 0, '0);

    // Fill from reset: first request addr 0, valid two cycles later, then one per cycle
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, '0);
      if (i == 0) begin
        chk("t1_req0", 32'(obs_req), 32'h1);
        chk("t1_addr0", 32'(obs_raddr), 32'h0);
      end
      if (i == 1) chk("t1_vld_early", 32'(obs_vld), 32'h0);
      if (i == 2) chk("t1_first", 32'(obs_iaddr), 32'h0);
      if (i == 3) chk("t1_second", 32'(obs_iaddr), 32'h1);
    end

    // Hold for 5 cycles: fetch stops with 2 buffered
    for (int i = 0; i < 5; i++) step(0, 1, 0, '0);
    chk("t2_req_off", 32'(obs_req), 32'h0);
    chk("t2_vld", 32'(obs_vld), 32'h1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0);

    // Mid-stream jump to 0x100
    step(0, 0, 1, 12'h100);
    chk("t3_jaddr", 32'(obs_raddr), 32'h100);
    step(0, 0, 0, '0);
    chk("t3_flushed", 32'(obs_vld), 32'h0);
    step(0, 0, 0, '0);
    chk("t3_tgt", 32'(obs_iaddr), 32'h100);
    step(0, 0, 0, '0);
    chk("t3_tgt1", 32'(obs_iaddr), 32'h101);

    // Jump while holding with the FIFO full
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0);
    step(0, 1, 1, 12'h200);
    step(0, 1, 0, '0);
    chk("t4_flushed", 32'(obs_vld), 32'h0);
    step(0, 0, 0, '0);
    chk("t4_tgt", 32'(obs_iaddr), 32'h200);
    step(0, 0, 0, '0);

    // Wrap at top of ROM
    step(0, 0, 1, 12'hFFF);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    chk("t5_fff", 32'(obs_iaddr), 32'hFFF);
    step(0, 0, 0, '0);
    chk("t5_000", 32'(obs_iaddr), 32'h000);
    step(0, 0, 0, '0);
    chk("t5_001", 32'(obs_iaddr), 32'h001);

    // Reset mid-stream
    step(1, 0, 0, '0);
    chk("t6_vld", 32'(obs_vld), 32'h0);
    chk("t6_instr", obs_instr, NOP);
    step(0, 0, 0, '0);
    chk("t6_restart", 32'(obs_raddr), 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 149) == 0);
      h = ($urandom_range(0, 99) < 30);
      j = ($urandom_range(0, 99) < 7);
      if ($urandom_range(0, 3) == 0) ja = 12'hFFD + AW'($urandom_range(0, 2));
      else ja = AW'($urandom);
      step(r, h, j, ja);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
